hex_display_arbiter: RTL and testbench



---
 rtl/hex_display_arbiter_if.sv | 28 ++
 rtl/hex_display_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_hex_display_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hex_display_arbiter_if.sv
// Bus between the digit sources and hex_display_arbiter.
//   req         : level request per source
//   digits      : source i digit at [4i+3:4i]
//   grant       : one-hot grant, all zero when idle
//   digit_out   : digit of the granted source (feeds the HEX converter)
//   digit_valid : 1 = show digit_out, 0 = blank
//   done        : one-cycle pulse to a source when its dwell completes
// master = source side, slave = arbiter side.
interface hex_display_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [4*NUM_REQ-1:0] digits;
  logic [NUM_REQ-1:0]   grant;
  logic [3:0]           digit_out;
  logic                 digit_valid;
  logic [NUM_REQ-1:0]   done;

  modport master (
    output req, digits,
    input  grant, digit_out, digit_valid, done
  );

  modport slave (
    input  req, digits,
    output grant, digit_out, digit_valid, done
  );
endinterface

// File: rtl/hex_display_arbiter.sv
// Round-robin arbiter sharing one seven-segment digit path between NUM_REQ
// sources. Each grant is shown for DWELL_CYCLES cycles, followed by an
// optional GAP_CYCLES blank gap.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : hex_display_arbiter_if.slave (req, digits in; grant, digit_out,
//           digit_valid, done out; all outputs registered)
// Optional feature macro: DISPLAY_ARB_PRIO0_EN -- requester 0 gets absolute
// priority and preempts other sources during SHOW/GAP.
module hex_display_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DWELL_CYCLES = 25000000,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input logic                  clk,
  input logic                  reset,
  hex_display_arbiter_if.slave bus
);

  localparam int unsigned IW   = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CMAX = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  localparam int unsigned CW   = (CMAX > 2) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      rr_q, rr_d;
  logic [IW-1:0]      cur_q, cur_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [3:0]         digit_q, digit_d;
  logic               valid_q, valid_d;
  logic [NUM_REQ-1:0] done_q, done_d;

  logic               win_found;
  logic               prio_win;
  logic [IW-1:0]      win_idx;
  logic [IW:0]        cand;
  logic [IW:0]        rr_next;

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB;
      rr_q    <= '0;
      cur_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      digit_q <= '0;
      valid_q <= 1'b0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      digit_q <= digit_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    cur_d     = cur_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    digit_d   = digit_q;
    valid_d   = valid_q;
    done_d    = '0;
    win_found = 1'b0;
    prio_win  = 1'b0;
    win_idx   = '0;
    cand      = '0;
    rr_next   = '0;

    // Circular scan starting at the rr pointer; first hit wins
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      cand = {1'b0, rr_q} + (IW+1)'(i);
      if (cand >= (IW+1)'(NUM_REQ)) begin
        cand = cand - (IW+1)'(NUM_REQ);
      end
      if (!win_found && bus.req[cand[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IW-1:0];
      end
    end

`ifdef DISPLAY_ARB_PRIO0_EN
    // Requester 0 overrides the rotation and leaves the pointer untouched
    if (bus.req[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
      prio_win  = 1'b1;
    end
`endif

    rr_next = {1'b0, win_idx} + (IW+1)'(1);
    if (rr_next >= (IW+1)'(NUM_REQ)) begin
      rr_next = '0;
    end

    case (state_q)
      ARB: begin
        if (win_found) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          digit_d          = bus.digits[{win_idx, 2'b00} +: 4];
          valid_d          = 1'b1;
          cnt_d            = '0;
          cur_d            = win_idx;
          if (!prio_win) begin
            rr_d = rr_next[IW-1:0];
          end
          state_d = SHOW;
        end
      end

      SHOW: begin
        // Terminal count ends the grant with done; a dropped req aborts silently
        if (cnt_q == DWELL_LAST || !bus.req[cur_q]) begin
          if (cnt_q == DWELL_LAST) begin
            done_d[cur_q] = 1'b1;
          end
          grant_d = '0;
          valid_d = 1'b0;
          cnt_d   = '0;
          state_d = (GAP_CYCLES > 0) ? GAP : ARB;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ARB;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = ARB;
        grant_d = '0;
        valid_d = 1'b0;
        cnt_d   = '0;
      end
    endcase

`ifdef DISPLAY_ARB_PRIO0_EN
    // Preempt another source's SHOW or GAP: no done, no gap, fresh dwell
    if ((state_q == SHOW || state_q == GAP) && cur_q != '0 && bus.req[0]) begin
      done_d     = '0;
      grant_d    = '0;
      grant_d[0] = 1'b1;
      digit_d    = bus.digits[3:0];
      valid_d    = 1'b1;
      cnt_d      = '0;
      cur_d      = '0;
      state_d    = SHOW;
    end
`endif
  end

  assign bus.grant       = grant_q;
  assign bus.digit_out   = digit_q;
  assign bus.digit_valid = valid_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Scoreboard bench for hex_display_arbiter (NUM_REQ=4, DWELL=4, GAP=2).
// Stimulus pushes expected grant/end/done events with absolute cycle stamps;
// a negedge monitor pops and compares whenever the DUT shows such an event.
module tb_hex_display_arbiter;
  localparam int unsigned N = 4;
  localparam int K_GRANT = 0;
  localparam int K_END   = 1;
  localparam int K_DONE  = 2;

  typedef struct {
    int         kind;
    logic [3:0] vec;
    logic [3:0] dig;
    int         cyc;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  ev_t  expq[$];
  logic [3:0] exp_dig = 4'd0;
  logic [3:0] prev_grant = 4'd0;
  int   g, m, r;
  int   dv[4] = '{3, 5, 8, 9};

  hex_display_arbiter_if #(.NUM_REQ(N)) bif ();

  hex_display_arbiter #(
    .NUM_REQ     (N),
    .DWELL_CYCLES(4),
    .GAP_CYCLES  (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endtask

  task automatic push(input int kind, input logic [3:0] vec, input logic [3:0] dig, input int c);
    ev_t e;
    e.kind = kind;
    e.vec  = vec;
    e.dig  = dig;
    e.cyc  = c;
    expq.push_back(e);
  endtask

  // Full dwell of source s granted at cycle gc: done and grant drop 4 cycles later
  task automatic push_full(input int s, input logic [3:0] dig, input int gc);
    push(K_GRANT, 4'(1 << s), dig, gc);
    push(K_DONE, 4'(1 << s), 4'd0, gc + 4);
    push(K_END, 4'd0, 4'd0, gc + 4);
  endtask

  task automatic got_ev(input int kind, input logic [3:0] vec, input logic [3:0] dig);
    ev_t e;
    checks++;
    if (expq.size() == 0) begin
      $display("FAIL unexpected_event: got kind %0d vec %b at cycle %0d, expected none", kind, vec, cyc);
      return;
    end
    e = expq.pop_front();
    if (kind == K_GRANT) exp_dig = e.dig;
    if (e.kind == kind && e.vec == vec && e.cyc == cyc && (kind != K_GRANT || e.dig == dig))
      passes++;
    else
      $display("FAIL event: got kind %0d vec %b digit %0d cycle %0d, expected kind %0d vec %b digit %0d cycle %0d",
               kind, vec, dig, cyc, e.kind, e.vec, e.dig, e.cyc);
  endtask

  // Monitor: order within a cycle is done, grant drop, new grant
  always @(negedge clk) begin
    if (reset) begin
      prev_grant = 4'd0;
    end else begin
      if (bif.done != 4'd0) got_ev(K_DONE, bif.done, 4'd0);
      if (bif.grant == 4'd0 && prev_grant != 4'd0) got_ev(K_END, 4'd0, 4'd0);
      if (bif.grant != 4'd0 && bif.grant != prev_grant) got_ev(K_GRANT, bif.grant, bif.digit_out);
      if (bif.digit_valid) check("digit_hold", 32'(bif.digit_out), 32'(exp_dig));
      check("valid_vs_grant", 32'(bif.digit_valid), 32'(bif.grant != 4'd0));
      prev_grant = bif.grant;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    bif.req  = '0;
    bif.digits = '0;
    step(2);
    reset = 1'b0;
  endtask

  task automatic end_test(input string name);
    check(name, 32'(expq.size()), 32'd0);
    expq.delete();
  endtask

  initial begin
    reset      = 1'b1;
    bif.req    = '0;
    bif.digits = '0;
    #1;
    check("rst_grant", 32'(bif.grant), 32'd0);
    check("rst_digit", 32'(bif.digit_out), 32'd0);
    check("rst_valid", 32'(bif.digit_valid), 32'd0);
    check("rst_done", 32'(bif.done), 32'd0);

    // Single source, repeated re-grant every 7 cycles
    do_reset();
    m = cyc;
    bif.digits[3:0] = 4'd7;
    bif.req = 4'b0001;
    g = m + 1;
    push_full(0, 4'd7, g);
    push_full(0, 4'd7, g + 7);
    wait_until(g + 12);
    bif.req = '0;
    wait_until(g + 16);
    end_test("t1_leftover");

    // All sources active: strict rotation
    do_reset();
    m = cyc;
    bif.digits = {4'd9, 4'd8, 4'd5, 4'd3};
    bif.req = 4'b1111;
    g = m + 1;
    for (int k = 0; k < 5; k++) push_full(k % 4, 4'(dv[k % 4]), g + 7 * k);
    wait_until(g + 33);
    bif.req = '0;
    wait_until(g + 37);
    end_test("t2_leftover");

    // Digit frozen while source 2 is shown
    do_reset();
    m = cyc;
    bif.digits[11:8] = 4'd5;
    bif.req = 4'b0100;
    g = m + 1;
    push_full(2, 4'd5, g);
    wait_until(g + 1);
    bif.digits[11:8] = 4'd1;
    wait_until(g + 5);
    bif.req = '0;
    wait_until(g + 9);
    end_test("t3_leftover");

    // Abort: req[1] dropped in first dwell cycle, then source 3 after GAP
    do_reset();
    m = cyc;
    bif.digits[7:4]   = 4'd4;
    bif.digits[15:12] = 4'd6;
    bif.req = 4'b1010;
    g = m + 1;
    push(K_GRANT, 4'b0010, 4'd4, g);
    push(K_END, 4'd0, 4'd0, g + 1);
    push_full(3, 4'd6, g + 4);
    wait_until(g);
    bif.req = 4'b1000;
    wait_until(g + 9);
    bif.req = '0;
    wait_until(g + 13);
    end_test("t4_leftover");

    // Reset mid-SHOW clears outputs at once; restart from index 0
    do_reset();
    m = cyc;
    bif.digits[7:4]  = 4'd2;
    bif.digits[11:8] = 4'd10;
    bif.req = 4'b0110;
    g = m + 1;
    push(K_GRANT, 4'b0010, 4'd2, g);
    wait_until(g + 1);
    reset = 1'b1;
    #1;
    check("mid_rst_grant", 32'(bif.grant), 32'd0);
    check("mid_rst_digit", 32'(bif.digit_out), 32'd0);
    check("mid_rst_valid", 32'(bif.digit_valid), 32'd0);
    check("mid_rst_done", 32'(bif.done), 32'd0);
    step(1);
    reset = 1'b0;
    r = cyc;
    push_full(1, 4'd2, r + 1);
    wait_until(r + 6);
    bif.req = '0;
    wait_until(r + 10);
    end_test("t5_leftover");

    // Source 3 showing when req[0] rises
    do_reset();
    m = cyc;
    bif.digits[3:0]   = 4'd1;
    bif.digits[15:12] = 4'd9;
    bif.req = 4'b1000;
    g = m + 1;
    push(K_GRANT, 4'b1000, 4'd9, g);
`ifdef DISPLAY_ARB_PRIO0_EN
    push(K_GRANT, 4'b0001, 4'd1, g + 2);
    push(K_DONE, 4'b0001, 4'd0, g + 6);
    push(K_END, 4'd0, 4'd0, g + 6);
    wait_until(g + 1);
    bif.req = 4'b1001;
    wait_until(g + 7);
    bif.req = '0;
    wait_until(g + 12);
`else
    push(K_DONE, 4'b1000, 4'd0, g + 4);
    push(K_END, 4'd0, 4'd0, g + 4);
    push_full(0, 4'd1, g + 7);
    wait_until(g + 1);
    bif.req = 4'b1001;
    wait_until(g + 12);
    bif.req = '0;
    wait_until(g + 16);
`endif
    end_test("t6_leftover");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
